// File: rtl/alu_op_sequencer.sv
// Command/response sequencer and accumulator in front of a 4-bit combinational ALU.
// Optional feature macro: ALU_SEQ_CARRY_CHAIN_EN (add uses the previous op's carry-out).
module alu_op_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_cin,
  output logic [2:0]       alu_mode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_next;

  logic             op_load;
  logic             op_cin;
  logic [2:0]       op_mode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result_next;
  logic [3:0]       flags_next;
  logic             cin_select;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  logic carry_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_flag <= 1'b0;
    end else if (state == EXEC) begin
      carry_flag <= op_load ? 1'b0 : alu_cout;
    end
  end

  assign cin_select = carry_flag;
`else
  assign cin_select = cmd_cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Loads bypass the ALU, so their flags are derived locally from the load value.
  always_comb begin
    result_next = alu_result;
    flags_next  = {alu_cout, alu_overflow, alu_zero, alu_result[WIDTH-1]};
    if (op_load) begin
      result_next = op_b;
      flags_next  = {1'b0, 1'b0, (op_b == '0), op_b[WIDTH-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_load    <= 1'b0;
      op_cin     <= 1'b0;
      op_mode    <= 3'b000;
      op_a       <= '0;
      op_b       <= '0;
      acc        <= '0;
      rsp_result <= '0;
      rsp_flags  <= 4'b0000;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_load <= cmd_load;
            op_mode <= cmd_mode;
            op_b    <= cmd_b;
            op_a    <= acc;
            op_cin  <= cin_select;
          end
        end
        EXEC: begin
          rsp_result <= result_next;
          rsp_flags  <= flags_next;
          if (op_load) begin
            acc <= op_b;
          end else if (op_mode <= 3'b101) begin
            acc <= alu_result;
          end
        end
        RESP: begin
          if (rsp_ready && (op_count != '1)) begin
            op_count <= op_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // op_a mirrors acc while EXEC evaluates, but keeps alu_a steady once acc updates.
  assign alu_mode  = op_mode;
  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_cin   = (op_mode == 3'b000) ? op_cin : 1'b0;
  assign rsp_valid = (state == RESP);
  assign cmd_ready = (state == IDLE) && rst_n;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; includes a behavioural model of the 4-bit ALU.
// Build with ALU_SEQ_CARRY_CHAIN_EN defined to check the carry-chain variant.
module tb_alu_op_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [2:0]       cmd_mode;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_cin;
  logic [2:0]       alu_mode;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;
  logic             alu_overflow;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] op_count;

  int checks;
  int failures;

  logic [3:0] res;
  logic [3:0] flg;
  logic [3:0] exec_a;
  logic [3:0] exec_b;
  logic       exec_cin;
  logic [3:0] exp_val;

  alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_load     (cmd_load),
    .cmd_mode     (cmd_mode),
    .cmd_b        (cmd_b),
    .cmd_cin      (cmd_cin),
    .alu_mode     (alu_mode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_cin      (alu_cin),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .acc          (acc),
    .op_count     (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: sub is a + ~b + 1 so its carry-out means "no borrow".
  logic [4:0] sum;
  always_comb begin
    sum          = 5'd0;
    alu_result   = 4'h0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_mode)
      3'b000: begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
        alu_result   = sum[3:0];
        alu_cout     = sum[4];
        alu_overflow = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
      end
      3'b001: begin
        sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_result   = sum[3:0];
        alu_cout     = sum[4];
        alu_overflow = (alu_a[3] != alu_b[3]) && (sum[3] != alu_a[3]);
      end
      3'b010:  alu_result = ~alu_a;
      3'b011:  alu_result = alu_a & alu_b;
      3'b100:  alu_result = alu_a | alu_b;
      3'b101:  alu_result = alu_a ^ alu_b;
      3'b110:  alu_result = {3'b000, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = {3'b000, (alu_a == alu_b)};
    endcase
    alu_zero = (alu_result == 4'h0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction: wait for ready, issue, observe EXEC and RESP, then acknowledge.
  task automatic applyStimulus(input logic ld, input logic [2:0] mode, input logic [3:0] b,
                               input logic cin, output logic [3:0] r, output logic [3:0] f);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_ready_wait", cmd_ready, 1);
    cmd_load  = ld;
    cmd_mode  = mode;
    cmd_b     = b;
    cmd_cin   = cin;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    exec_a    = alu_a;
    exec_b    = alu_b;
    exec_cin  = alu_cin;
    checkOutput("exec_no_rsp", rsp_valid, 0);
    @(negedge clk);
    checkOutput("rsp_latency", rsp_valid, 1);
    r = rsp_result;
    f = rsp_flags;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_drop", rsp_valid, 0);
  endtask

  initial begin
    bit seen;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_mode  = 3'b000;
    cmd_b     = 4'h0;
    cmd_cin   = 1'b0;
    rsp_ready = 1'b0;

    #2;
    checkOutput("reset_acc", acc, 0);
    checkOutput("reset_count", op_count, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_cmd_ready", cmd_ready, 1);

    // Load then add with overflow into the sign bit.
    applyStimulus(1'b1, 3'b000, 4'h5, 1'b0, res, flg);
    checkOutput("load5_result", res, 4'h5);
    checkOutput("load5_flags", flg, 4'b0000);
    applyStimulus(1'b0, 3'b000, 4'h3, 1'b0, res, flg);
    checkOutput("add53_exec_a", exec_a, 4'h5);
    checkOutput("add53_exec_b", exec_b, 4'h3);
    checkOutput("add53_result", res, 4'h8);
    checkOutput("add53_flags", flg, 4'b0101);
    checkOutput("add53_acc", acc, 4'h8);

    // Wrap-around add.
    applyStimulus(1'b1, 3'b000, 4'hF, 1'b0, res, flg);
    checkOutput("loadF_flags", flg, 4'b0001);
    applyStimulus(1'b0, 3'b000, 4'h1, 1'b0, res, flg);
    checkOutput("addF1_result", res, 4'h0);
    checkOutput("addF1_flags", flg, 4'b1010);
    checkOutput("addF1_acc", acc, 4'h0);
    checkOutput("count_after4", op_count, 4);

    // Follow-up add with cin=0 picks up the stored carry only in carry-chain builds.
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    exp_val = 4'h1;
`else
    exp_val = 4'h0;
`endif
    applyStimulus(1'b0, 3'b000, 4'h0, 1'b0, res, flg);
    checkOutput("chain_add_result", res, exp_val);

    // Compares leave acc untouched.
    applyStimulus(1'b1, 3'b000, 4'h3, 1'b0, res, flg);
    applyStimulus(1'b0, 3'b110, 4'h5, 1'b0, res, flg);
    checkOutput("slt35_result", res, 4'h1);
    checkOutput("slt35_acc", acc, 4'h3);
    applyStimulus(1'b0, 3'b111, 4'h3, 1'b0, res, flg);
    checkOutput("eq33_result", res, 4'h1);
    checkOutput("eq33_acc", acc, 4'h3);

    // Subtract and xor; xor must not forward cmd_cin.
    applyStimulus(1'b0, 3'b001, 4'h5, 1'b0, res, flg);
    checkOutput("sub35_result", res, 4'hE);
    checkOutput("sub35_flags", flg, 4'b0001);
    checkOutput("sub35_acc", acc, 4'hE);
    applyStimulus(1'b0, 3'b101, 4'h6, 1'b1, res, flg);
    checkOutput("xor_exec_cin", exec_cin, 0);
    checkOutput("xor_result", res, 4'h8);
    checkOutput("xor_acc", acc, 4'h8);

    // Add with cmd_cin=1: forwarded normally, ignored with carry chain (load cleared C).
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    exp_val = 4'h2;
`else
    exp_val = 4'h3;
`endif
    applyStimulus(1'b1, 3'b000, 4'h1, 1'b0, res, flg);
    applyStimulus(1'b0, 3'b000, 4'h1, 1'b1, res, flg);
    checkOutput("add_cin_result", res, exp_val);
    checkOutput("add_cin_exec", exec_cin, (exp_val == 4'h3));

    // Backpressure: response held, later command not accepted.
    applyStimulus(1'b1, 3'b000, 4'h2, 1'b0, res, flg);
    @(negedge clk);
    cmd_load  = 1'b0;
    cmd_mode  = 3'b000;
    cmd_b     = 4'h1;
    cmd_cin   = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_load = 1'b1;
    cmd_b    = 4'h9;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_rsp_valid", rsp_valid, 1);
      checkOutput("hold_rsp_result", rsp_result, 4'h3);
      checkOutput("hold_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("hold_acc", acc, 4'h3);
    checkOutput("hold_count", op_count, 14);

    // Reset during EXEC drops the in-flight command.
    @(negedge clk);
    cmd_load  = 1'b0;
    cmd_mode  = 3'b101;
    cmd_b     = 4'hA;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("pre_reset_alu_b", alu_b, 4'hA);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_alu_b", alu_b, 0);
    checkOutput("mid_reset_alu_mode", alu_mode, 0);
    checkOutput("mid_reset_acc", acc, 0);
    checkOutput("mid_reset_count", op_count, 0);
    checkOutput("mid_reset_rsp", {rsp_valid, rsp_result, rsp_flags}, 0);
    checkOutput("mid_reset_cmd_ready", cmd_ready, 0);
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checkOutput("post_reset_no_rsp", seen, 0);

    // Counter saturation.
    for (int i = 0; i < 257; i++) begin
      applyStimulus(1'b1, 3'b000, 4'h7, 1'b0, res, flg);
    end
    checkOutput("count_saturated", op_count, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
